// File: rtl/inst_dispatch_pkg.sv
// Shared definitions for the instruction dispatcher: opcode values, field
// positions of the 32-bit instruction word, FSM encoding and decode helper.
package inst_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_CONV  = 4'h3;
  localparam logic [3:0] OP_FC    = 4'h4;
  localparam logic [3:0] OP_SYNC  = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 28;
  localparam int DST_MSB  = 27;
  localparam int DST_LSB  = 24;
  localparam int ARG1_MSB = 23;
  localparam int ARG1_LSB = 12;
  localparam int ARG2_MSB = 11;
  localparam int ARG2_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_SYNC_WAIT = 2'd2,
    ST_HALT      = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_CMD     = 3'd1,
    CLS_SYNC    = 3'd2,
    CLS_HALT    = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [11:0] arg1;
    logic [11:0] arg2;
  } cmd_t;

  function automatic op_class_e classify(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_NOP:                          cls = CLS_NOP;
      OP_LOAD, OP_STORE, OP_CONV, OP_FC: cls = CLS_CMD;
      OP_SYNC:                         cls = CLS_SYNC;
      OP_HALT:                         cls = CLS_HALT;
      default:                         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/inst_dispatch_fifo.sv
// Synchronous FIFO buffering fetched instructions; a word pushed into an
// empty FIFO becomes visible to pop only from the following cycle.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [IW-1:0] wdata,
  input  logic          pop,
  output logic [IW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == {(AW+1){1'b0}});
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; pointers wrap mod DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards contents as well as pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {IW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_dispatch.sv
// Instruction dispatcher: buffers fetched words, decodes them, issues
// LOAD/STORE/CONV/FC commands and executes SYNC/HALT locally.
module inst_dispatch
  import inst_pkg::*;
#(
  parameter int IW    = 32,
  parameter int DEPTH = 4,
  parameter int OW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] instgen_s_data,
  input  logic          instgen_s_valid,
  output logic          instgen_s_ready,
  output logic          cmd_m_valid,
  input  logic          cmd_m_ready,
  output logic [3:0]    cmd_m_op,
  output logic [3:0]    cmd_m_dst,
  output logic [11:0]   cmd_m_arg1,
  output logic [11:0]   cmd_m_arg2,
  input  logic          cmd_done,
  output logic          halted,
  output logic          err_illegal
);

  localparam logic [OW-1:0] OUT_MAX  = {OW{1'b1}};
  localparam logic [OW-1:0] OUT_ZERO = {OW{1'b0}};

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  cmd_t          head;
  logic [OW-1:0] out_q, out_d;
  logic          err_q, err_d;
  logic          rdy_en_q, rdy_en_d;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [IW-1:0] fifo_rdata;
  logic          accept, illegal_pop, underflow;

  // Ready is held low through reset and rises on the first clock after it.
  assign rdy_en_d        = 1'b1;
  assign instgen_s_ready = rdy_en_q && !fifo_full;
  assign fifo_push       = instgen_s_valid && instgen_s_ready;

  inst_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (instgen_s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head.op   = fifo_rdata[OP_MSB:OP_LSB];
  assign head.dst  = fifo_rdata[DST_MSB:DST_LSB];
  assign head.arg1 = fifo_rdata[ARG1_MSB:ARG1_LSB];
  assign head.arg2 = fifo_rdata[ARG2_MSB:ARG2_LSB];

  // A command is withheld while the outstanding counter is saturated.
  assign cmd_m_valid = (state_q == ST_ISSUE) && (out_q != OUT_MAX);
  assign accept      = cmd_m_valid && cmd_m_ready;
  assign cmd_m_op    = cmd_q.op;
  assign cmd_m_dst   = cmd_q.dst;
  assign cmd_m_arg1  = cmd_q.arg1;
  assign cmd_m_arg2  = cmd_q.arg2;
  assign halted      = (state_q == ST_HALT);
  assign err_illegal = err_q;

  // Dispatch FSM: at most one pop per cycle, only from IDLE.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    fifo_pop    = 1'b0;
    illegal_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          case (classify(head.op))
            CLS_NOP:     state_d = ST_IDLE;
            CLS_SYNC:    state_d = ST_SYNC_WAIT;
            CLS_HALT:    state_d = ST_HALT;
            CLS_CMD: begin
              cmd_d   = head;
              state_d = ST_ISSUE;
            end
            CLS_ILLEGAL: begin
              illegal_pop = 1'b1;
              state_d     = ST_IDLE;
            end
            default:     state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_SYNC_WAIT: begin
        if (out_q == OUT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SYNC_WAIT;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outstanding counter: accept and completion in one cycle cancel out;
  // a completion with nothing outstanding is flagged and ignored.
  always_comb begin
    out_d     = out_q;
    underflow = 1'b0;
    case ({accept, cmd_done})
      2'b10: out_d = out_q + OW'(1);
      2'b01: begin
        if (out_q == OUT_ZERO) begin
          underflow = 1'b1;
          out_d     = out_q;
        end else begin
          out_d = out_q - OW'(1);
        end
      end
      default: out_d = out_q;
    endcase
    err_d = err_q | illegal_pop | underflow;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '{op: 4'h0, dst: 4'h0, arg1: 12'h000, arg2: 12'h000};
      out_q    <= OUT_ZERO;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      out_q    <= out_d;
      err_q    <= err_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_inst_dispatch.sv
// Self-checking bench for inst_dispatch: randomized and directed stimulus
// scored against an in-order instruction-stream model.
module tb_inst_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instgen_s_data = 32'h0;
  logic        instgen_s_valid = 1'b0;
  logic        instgen_s_ready;
  logic        cmd_m_valid;
  logic        cmd_m_ready = 1'b0;
  logic [3:0]  cmd_m_op, cmd_m_dst;
  logic [11:0] cmd_m_arg1, cmd_m_arg2;
  logic        cmd_done = 1'b0;
  logic        halted, err_illegal;

  always #5 clk = ~clk;

  inst_dispatch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instgen_s_data  (instgen_s_data),
    .instgen_s_valid (instgen_s_valid),
    .instgen_s_ready (instgen_s_ready),
    .cmd_m_valid     (cmd_m_valid),
    .cmd_m_ready     (cmd_m_ready),
    .cmd_m_op        (cmd_m_op),
    .cmd_m_dst       (cmd_m_dst),
    .cmd_m_arg1      (cmd_m_arg1),
    .cmd_m_arg2      (cmd_m_arg2),
    .cmd_done        (cmd_done),
    .halted          (halted),
    .err_illegal     (err_illegal)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] to_send[$];
  logic [31:0] model_q[$];
  int  m_out, issued, exp_issue, cyc;
  int  rdy_pct, done_pct;
  bit  force_done, exp_err, halt_enq, stall_prev;
  logic [31:0] stall_fields;
  int  last_acc_cyc, first_valid_cyc;

  function automatic bit is_cmd(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h4);
  endfunction

  function automatic bit is_illegal(input logic [3:0] op);
    return (op >= 4'h6) && (op <= 4'hE);
  endfunction

  task automatic send(input logic [31:0] w);
    to_send.push_back(w);
    if (!halt_enq) begin
      if (is_cmd(w[31:28])) exp_issue++;
      if (is_illegal(w[31:28])) exp_err = 1'b1;
      if (w[31:28] == 4'hF) halt_enq = 1'b1;
    end
  endtask

  // Consume the model stream up to the next expected command and compare.
  task automatic score();
    logic [31:0] w;
    logic [31:0] got;
    bit synced, found, stop;
    synced = 1'b0; found = 1'b0; stop = 1'b0;
    got = {cmd_m_op, cmd_m_dst, cmd_m_arg1, cmd_m_arg2};
    while (!stop && model_q.size() > 0) begin
      w = model_q.pop_front();
      if (is_cmd(w[31:28])) begin
        found = 1'b1; stop = 1'b1;
      end else if (w[31:28] == 4'h5) begin
        synced = 1'b1;
      end else if (w[31:28] == 4'hF) begin
        model_q.push_front(w); stop = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL unexpected_issue: got cmd %h expected no command", got);
    end else if (got !== w) begin
      failures++;
      $display("FAIL cmd_fields: got %h expected %h", got, w);
    end
    if (synced) begin
      checks++;
      if (m_out != 0) begin
        failures++;
        $display("FAIL sync_drain: got outstanding %0d at issue expected 0", m_out);
      end
    end
    issued++;
  endtask

  // One clock: drive inputs, sample at negedge, update model, advance.
  task automatic step();
    bit hs_in, hs_cmd;
    instgen_s_valid = (to_send.size() > 0);
    instgen_s_data  = (to_send.size() > 0) ? to_send[0] : $urandom;
    cmd_m_ready     = ($urandom_range(99) < rdy_pct);
    cmd_done        = force_done || ((m_out > 0) && ($urandom_range(99) < done_pct));
    @(negedge clk);
    hs_in  = instgen_s_valid && instgen_s_ready;
    hs_cmd = cmd_m_valid && cmd_m_ready;
    if (stall_prev) begin
      checks++;
      if (cmd_m_valid !== 1'b1 || {cmd_m_op, cmd_m_dst, cmd_m_arg1, cmd_m_arg2} !== stall_fields) begin
        failures++;
        $display("FAIL stall_stable: got valid=%b cmd=%h expected valid=1 cmd=%h",
                 cmd_m_valid, {cmd_m_op, cmd_m_dst, cmd_m_arg1, cmd_m_arg2}, stall_fields);
      end
    end
    if (cmd_m_valid) begin
      checks++;
      if (m_out >= 7) begin
        failures++;
        $display("FAIL outstanding_limit: got valid with %0d outstanding expected <7", m_out);
      end
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    stall_prev   = cmd_m_valid && !cmd_m_ready;
    stall_fields = {cmd_m_op, cmd_m_dst, cmd_m_arg1, cmd_m_arg2};
    if (hs_in) begin
      model_q.push_back(to_send.pop_front());
      last_acc_cyc = cyc;
    end
    if (hs_cmd) score();
    if (cmd_done && m_out == 0 && !hs_cmd) exp_err = 1'b1;
    m_out = m_out + int'(hs_cmd);
    if (cmd_done) m_out = (m_out > 0) ? m_out - 1 : 0;
    @(posedge clk);
    #1;
    cyc++;
    cmd_done = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_model();
    to_send.delete(); model_q.delete();
    m_out = 0; issued = 0; exp_issue = 0; exp_err = 1'b0; halt_enq = 1'b0;
    stall_prev = 1'b0; force_done = 1'b0; first_valid_cyc = -1; last_acc_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; instgen_s_valid = 1'b0; cmd_m_ready = 1'b0; cmd_done = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instgen_s_valid = 1'b0; cmd_m_ready = 1'b0; cmd_done = 1'b0;
    clear_model();
    @(posedge clk); #2;
    checks++;
    if (instgen_s_ready !== 1'b0 || cmd_m_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b valid=%b expected 0 0", instgen_s_ready, cmd_m_valid);
    end
    checks++;
    if (halted !== 1'b0 || err_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: got halted=%b err=%b expected 0 0", halted, err_illegal);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (instgen_s_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b expected 0", instgen_s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (instgen_s_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b expected 1", instgen_s_ready);
    end
  endtask

  task automatic test_latency_nop();
    do_reset();
    rdy_pct = 100; done_pct = 0;
    send(32'h1300_A005);
    run(6);
    checks++;
    if (first_valid_cyc - last_acc_cyc != 2) begin
      failures++;
      $display("FAIL latency: got %0d cycles expected 2", first_valid_cyc - last_acc_cyc);
    end
    checks++;
    if (issued != 1 || m_out != 1) begin
      failures++;
      $display("FAIL load_issue: got issued=%0d outstanding=%0d expected 1 1", issued, m_out);
    end
    first_valid_cyc = -1;
    send(32'h0100_0000);
    run(8);
    checks++;
    if (issued != 1 || first_valid_cyc != -1) begin
      failures++;
      $display("FAIL nop_silent: got issued=%0d valid_cycle=%0d expected 1 -1", issued, first_valid_cyc);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_pct = 0; done_pct = 0;
    for (int i = 0; i < 6; i++) send({4'h1 + 4'($urandom_range(3)), 28'($urandom)});
    run(12);
    checks++;
    if (6 - to_send.size() != 5 || instgen_s_ready !== 1'b0 || cmd_m_valid !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_fill: got accepted=%0d ready=%b valid=%b expected 5 0 1",
               6 - to_send.size(), instgen_s_ready, cmd_m_valid);
    end
    rdy_pct = 100; done_pct = 60;
    run(60);
    checks++;
    if (issued != 6) begin
      failures++;
      $display("FAIL backpressure_drain: got issued=%0d expected 6", issued);
    end
  endtask

  task automatic test_sync();
    do_reset();
    rdy_pct = 100; done_pct = 0;
    send(32'h3111_2223); send(32'h4444_5556); send(32'h5000_0000); send(32'h2777_8889);
    run(12);
    checks++;
    if (issued != 2) begin
      failures++;
      $display("FAIL sync_hold: got issued=%0d expected 2", issued);
    end
    force_done = 1'b1; step(); force_done = 1'b0;
    run(5);
    checks++;
    if (issued != 2) begin
      failures++;
      $display("FAIL sync_one_done: got issued=%0d expected 2", issued);
    end
    force_done = 1'b1; step(); force_done = 1'b0;
    run(6);
    checks++;
    if (issued != 3) begin
      failures++;
      $display("FAIL sync_release: got issued=%0d expected 3", issued);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    rdy_pct = 100; done_pct = 0;
    for (int i = 0; i < 8; i++) send({4'h1, 28'($urandom)});
    run(30);
    checks++;
    if (issued != 7 || cmd_m_valid !== 1'b0) begin
      failures++;
      $display("FAIL saturate: got issued=%0d valid=%b expected 7 0", issued, cmd_m_valid);
    end
    force_done = 1'b1; step(); force_done = 1'b0;
    run(4);
    checks++;
    if (issued != 8) begin
      failures++;
      $display("FAIL saturate_release: got issued=%0d expected 8", issued);
    end
    done_pct = 50;
    for (int i = 0; i < 10; i++) send({4'h1 + 4'($urandom_range(3)), 28'($urandom)});
    run(80);
    checks++;
    if (issued != 18) begin
      failures++;
      $display("FAIL saturate_mixed: got issued=%0d expected 18", issued);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    rdy_pct = 100; done_pct = 100;
    send(32'h7123_4567); send(32'h1abc_def0);
    run(10);
    checks++;
    if (err_illegal !== 1'b1 || issued != 1) begin
      failures++;
      $display("FAIL illegal_op: got err=%b issued=%0d expected 1 1", err_illegal, issued);
    end
    do_reset();
    force_done = 1'b1; step(); force_done = 1'b0;
    run(1);
    send(32'h2010_0200);
    run(6);
    checks++;
    if (err_illegal !== 1'b1 || issued != 1) begin
      failures++;
      $display("FAIL done_underflow: got err=%b issued=%0d expected 1 1", err_illegal, issued);
    end
  endtask

  task automatic test_halt();
    do_reset();
    rdy_pct = 100; done_pct = 100;
    send(32'h1222_3334); send(32'hF000_0000);
    for (int i = 0; i < 6; i++) send({4'h1, 28'($urandom)});
    run(30);
    checks++;
    if (halted !== 1'b1 || issued != 1) begin
      failures++;
      $display("FAIL halt: got halted=%b issued=%0d expected 1 1", halted, issued);
    end
    checks++;
    if (to_send.size() != 2 || instgen_s_ready !== 1'b0) begin
      failures++;
      $display("FAIL halt_fill: got left=%0d ready=%b expected 2 0", to_send.size(), instgen_s_ready);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || err_illegal !== 1'b0 || instgen_s_ready !== 1'b1) begin
      failures++;
      $display("FAIL halt_reset: got halted=%b err=%b ready=%b expected 0 0 1",
               halted, err_illegal, instgen_s_ready);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rdy_pct = 0; done_pct = 0;
    for (int i = 0; i < 6; i++) send({4'h3, 28'($urandom)});
    run(12);
    checks++;
    if (cmd_m_valid !== 1'b1 || instgen_s_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_precondition: got valid=%b ready=%b expected 1 0", cmd_m_valid, instgen_s_ready);
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if (cmd_m_valid !== 1'b0 || instgen_s_ready !== 1'b0 || cmd_m_op !== 4'h0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b ready=%b op=%h expected 0 0 0",
               cmd_m_valid, instgen_s_ready, cmd_m_op);
    end
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rdy_pct = 100;
    run(10);
    checks++;
    if (issued != 0 || first_valid_cyc != -1) begin
      failures++;
      $display("FAIL mid_discard: got issued=%0d valid_cycle=%0d expected 0 -1", issued, first_valid_cyc);
    end
  endtask

  task automatic test_random();
    int r;
    logic [3:0] op;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int i = 0; i < 40; i++) begin
        r = $urandom_range(19);
        if (r < 12)      op = 4'h1 + 4'($urandom_range(3));
        else if (r < 15) op = 4'h0;
        else if (r < 18) op = 4'h5;
        else if (r < 19) op = 4'h6 + 4'($urandom_range(8));
        else             op = 4'h2;
        send({op, 28'($urandom)});
      end
      rdy_pct = 70; done_pct = 40;
      run(300);
      rdy_pct = 100; done_pct = 100;
      run(60);
      checks++;
      if (issued != exp_issue || to_send.size() != 0) begin
        failures++;
        $display("FAIL random_count: got issued=%0d left=%0d expected %0d 0",
                 issued, to_send.size(), exp_issue);
      end
      checks++;
      if (err_illegal !== exp_err) begin
        failures++;
        $display("FAIL random_err: got %b expected %b", err_illegal, exp_err);
      end
    end
  endtask

  initial begin
    cyc = 0; rdy_pct = 0; done_pct = 0;
    test_reset();
    test_latency_nop();
    test_backpressure();
    test_sync();
    test_saturate();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
